// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive front end: FSM state encoding,
// the legal prescale values and the bit-index landmarks inside a frame.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Legal oversampling ratios; anything else decodes to PRESC_8.
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  // Width of the latched prescale and of the edge counter (holds up to 32).
  localparam int P_W = 6;

  // Bit index landmarks carried on bit_cnt.
  localparam logic [3:0] BIT_START  = 4'd0;
  localparam logic [3:0] BIT_PAR    = 4'd9;
  localparam logic [3:0] BIT_STOP_P = 4'd10;

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter and bit-decision logic.
// Build option: UART_RX_MAJ_SAMPLE_EN selects a 3-sample majority vote
// around mid-bit; otherwise a single sample is taken at mid-bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           active,
  input  logic           rx,
  input  logic [P_W-1:0] presc,
  output logic [P_W-1:0] edge_cnt,
  output logic           bit_end,
  output logic           sampled_bit
);

  logic [P_W-1:0] half;
  logic [P_W-1:0] last;

  assign half    = presc >> 1;
  assign last    = presc - P_W'(1);
  assign bit_end = active && (edge_cnt == last);

  // Edge counter: runs 0..P-1 while a frame is in progress, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!active || bit_end) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + P_W'(1);
    end
  end

`ifdef UART_RX_MAJ_SAMPLE_EN
  logic [P_W-1:0] half_m1;
  logic [P_W-1:0] half_p1;
  logic           s_early;
  logic           s_mid;

  assign half_m1 = half - P_W'(1);
  assign half_p1 = half + P_W'(1);

  // Collect two samples ahead of the vote; the third is the live line at P/2+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (active) begin
      if (edge_cnt == half_m1) s_early <= rx;
      if (edge_cnt == half)    s_mid   <= rx;
    end
  end

  // Register the majority decision at P/2+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampled_bit <= 1'b1;
    end else if (active && (edge_cnt == half_p1)) begin
      sampled_bit <= (s_early & s_mid) | (s_early & rx) | (s_mid & rx);
    end
  end
`else
  // Register a single mid-bit sample; visible from P/2+1 on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampled_bit <= 1'b1;
    end else if (active && (edge_cnt == half)) begin
      sampled_bit <= rx;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: start detect, frame sequencing and deserialisation.
// Feeds the downstream parity checker (sampled_bit, P_DATA, bit_cnt,
// par_chk_en) and consumes its par_err verdict.
// Build option: UART_RX_MAJ_SAMPLE_EN (majority sampling, see uart_rx_sampler).
//
// Handshake: there is no back-pressure. data_valid is a single-cycle pulse
// meaning "P_DATA holds an error-free byte now"; the consumer must take it in
// that cycle. par_err is only looked at on the last tick of the parity bit.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               par_err,
  output logic               sampled_bit,
  output logic [DATA_W-1:0]  P_DATA,
  output logic [3:0]         bit_cnt,
  output logic               par_chk_en,
  output logic               data_valid,
  output logic               stp_err,
  output logic               strt_glitch,
  output logic               par_typ,
  output rx_state_t          dbg_state,
  output logic [P_W-1:0]     dbg_edge_cnt
);

  rx_state_t      state;
  rx_state_t      state_next;
  logic [P_W-1:0] presc_dec;
  logic [P_W-1:0] presc_q;
  logic           par_en_q;
  logic           par_err_q;
  logic           bit_end;

  logic           start_det;
  logic           start_ok;
  logic           start_bad;
  logic           shift_en;
  logic           par_cap;
  logic           stop_end;

  uart_rx_sampler u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .active      (state != ST_IDLE),
    .rx          (RX_IN),
    .presc       (presc_q),
    .edge_cnt    (dbg_edge_cnt),
    .bit_end     (bit_end),
    .sampled_bit (sampled_bit)
  );

  assign par_chk_en = (state == ST_PARITY);
  assign dbg_state  = state;

  // Map the raw Prescale input onto a legal ratio.
  always_comb begin
    presc_dec = P_W'(PRESC_8);
    if (Prescale == PRESC_W'(PRESC_16)) presc_dec = P_W'(PRESC_16);
    if (Prescale == PRESC_W'(PRESC_32)) presc_dec = P_W'(PRESC_32);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    stop_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_next = ST_START;
          start_det  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            state_next = ST_IDLE;
            start_bad  = 1'b1;
          end else begin
            state_next = ST_DATA;
            start_ok   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(DATA_W)) state_next = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_cap    = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stop_end = 1'b1;
          // A low line on the last stop tick is already the next start bit.
          if (!RX_IN) begin
            state_next = ST_START;
            start_det  = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame datapath: configuration latch, bit counter, data byte and status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q     <= P_W'(PRESC_8);
      par_en_q    <= 1'b0;
      par_typ     <= 1'b0;
      par_err_q   <= 1'b0;
      bit_cnt     <= BIT_START;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_det) begin
        presc_q     <= presc_dec;
        par_en_q    <= PAR_EN;
        par_typ     <= PAR_TYP;
        par_err_q   <= 1'b0;
        bit_cnt     <= BIT_START;
        stp_err     <= 1'b0;
        strt_glitch <= 1'b0;
      end
      if (start_bad) begin
        strt_glitch <= 1'b1;
        bit_cnt     <= BIT_START;
      end
      if (start_ok) bit_cnt <= 4'd1;
      if (shift_en) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (bit_cnt == 4'(i + 1)) P_DATA[i] <= sampled_bit;
        end
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (par_cap) begin
        par_err_q <= par_err;
        bit_cnt   <= BIT_STOP_P;
      end
      // Stop verdict wins over the flag clear of a back-to-back start detect.
      if (stop_end) begin
        stp_err    <= ~sampled_bit;
        data_valid <= sampled_bit & ~(par_en_q & par_err_q);
        bit_cnt    <= BIT_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven on negedges, expected
// bytes go into a queue, and a monitor pops them on every data_valid.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic           CLK;
  logic           RST;
  logic           RX_IN;
  logic           PAR_EN;
  logic           PAR_TYP;
  logic [5:0]     Prescale;
  logic           par_err;
  logic           sampled_bit;
  logic [7:0]     P_DATA;
  logic [3:0]     bit_cnt;
  logic           par_chk_en;
  logic           data_valid;
  logic           stp_err;
  logic           strt_glitch;
  logic           par_typ;
  rx_state_t      dbg_state;
  logic [P_W-1:0] dbg_edge_cnt;

  int         pass_cnt;
  int         total_cnt;
  int         par_cycles;
  logic       dv_prev;
  logic [7:0] exp_q[$];

  uart_rx_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .par_err      (par_err),
    .sampled_bit  (sampled_bit),
    .P_DATA       (P_DATA),
    .bit_cnt      (bit_cnt),
    .par_chk_en   (par_chk_en),
    .data_valid   (data_valid),
    .stp_err      (stp_err),
    .strt_glitch  (strt_glitch),
    .par_typ      (par_typ),
    .dbg_state    (dbg_state),
    .dbg_edge_cnt (dbg_edge_cnt)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stand-in for the downstream parity checker.
  assign par_err = par_chk_en & (sampled_bit ^ (^P_DATA) ^ PAR_TYP);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: one pop per data_valid, pulses must be one cycle wide.
  always @(negedge CLK) begin
    if (RST && data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data_valid", 32'(P_DATA), 32'h1ff);
      end else begin
        check("p_data", 32'(P_DATA), 32'(exp_q.pop_front()));
      end
      if (dv_prev) check("data_valid_width", 32'd2, 32'd1);
    end
    if (RST && par_chk_en) begin
      par_cycles++;
      check("par_chk_en_bit_cnt", 32'(bit_cnt), 32'(BIT_PAR));
    end
    dv_prev <= data_valid;
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Drive one frame, period cycles per bit. glitch_idx >= 0 inverts that data
  // bit for the single cycle the DUT samples at mid-bit. mid_chg flips
  // Prescale/PAR_EN during data bit 2.
  task automatic send_frame(input logic [7:0] data, input bit p_en, input bit par_bit,
                            input bit stop_bit, input int presc_in, input int period,
                            input int glitch_idx, input bit mid_chg);
    logic [10:0] bits;
    int          nbits;
    Prescale = 6'(presc_in);
    PAR_EN   = p_en;
    bits     = '1;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (p_en) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      nbits    = 11;
    end else begin
      bits[9]  = stop_bit;
      nbits    = 10;
    end
    for (int k = 0; k < nbits; k++) begin
      for (int j = 0; j < period; j++) begin
        RX_IN = bits[k];
        if (glitch_idx >= 0 && k == glitch_idx + 1 && j == period / 2 + 1) RX_IN = ~bits[k];
        if (mid_chg && k == 3 && j == 0) begin
          Prescale = 6'd16;
          PAR_EN   = ~p_en;
        end
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    par_cycles = 0;
    dv_prev    = 1'b0;
    RST        = 1'b0;
    RX_IN      = 1'b1;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_p_data", 32'(P_DATA), 32'h0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    check("rst_sampled_bit", 32'(sampled_bit), 32'h1);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_stp_err", 32'(stp_err), 32'h0);
    check("rst_strt_glitch", 32'(strt_glitch), 32'h0);
    check("rst_par_chk_en", 32'(par_chk_en), 32'h0);
    RST = 1'b1;
    idle(4);

    // 1: P=8, no parity, 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0, 0, 1, 8, 8, -1, 0);
    idle(4);
    check("t1_stp_err", 32'(stp_err), 32'h0);
    check("t1_bit_cnt", 32'(bit_cnt), 32'h0);
    check("t1_state", 32'(dbg_state), 32'(ST_IDLE));

    // 2: P=16, even parity, 0x3C with parity 0
    PAR_TYP    = 1'b0;
    par_cycles = 0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1, 0, 1, 16, 16, -1, 0);
    idle(4);
    check("t2_par_cycles", 32'(par_cycles), 32'd16);
    check("t2_stp_err", 32'(stp_err), 32'h0);

    // 3: bad parity drops the frame, next good frame 0x55 is delivered
    send_frame(8'h3C, 1, 1, 1, 16, 16, -1, 0);
    idle(4);
    check("t3_bad_par_pdata", 32'(P_DATA), 32'h3C);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1, 0, 1, 16, 16, -1, 0);
    idle(4);
    // odd parity: 0x07 has three ones, parity bit 0
    PAR_TYP = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1, 0, 1, 8, 8, -1, 0);
    idle(4);
    check("t3_par_typ", 32'(par_typ), 32'h1);
    PAR_TYP = 1'b0;

    // 4: start glitch, 3 low samples at P=8
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    idle(20);
    check("t4_strt_glitch", 32'(strt_glitch), 32'h1);
    check("t4_bit_cnt", 32'(bit_cnt), 32'h0);
    check("t4_state", 32'(dbg_state), 32'(ST_IDLE));

    // 5: stop error on 0xFF, then back-to-back 0x01 / 0x80
    send_frame(8'hFF, 0, 0, 0, 8, 8, -1, 0);
    idle(4);
    check("t5_stp_err", 32'(stp_err), 32'h1);
    check("t5_bad_stop_pdata", 32'(P_DATA), 32'hFF);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    send_frame(8'h01, 0, 0, 1, 8, 8, -1, 0);
    send_frame(8'h80, 0, 0, 1, 8, 8, -1, 0);
    idle(4);
    check("t5_stp_err_clr", 32'(stp_err), 32'h0);
    check("t5_strt_glitch_clr", 32'(strt_glitch), 32'h0);

    // Prescale=32, then an illegal value decoding to 8, then a mid-frame change
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 0, 0, 1, 32, 32, -1, 0);
    idle(4);
    exp_q.push_back(8'h6B);
    send_frame(8'h6B, 0, 0, 1, 20, 8, -1, 0);
    idle(4);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 0, 0, 1, 8, 8, -1, 1);
    idle(4);

    // 6a: single-cycle glitch exactly on the mid-bit sample of data bit 1
`ifdef UART_RX_MAJ_SAMPLE_EN
    exp_q.push_back(8'h0F);
`else
    exp_q.push_back(8'h0D);
`endif
    send_frame(8'h0F, 0, 0, 1, 8, 8, 1, 0);
    idle(4);

    // 6b: reset during data bit 4
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      RX_IN = k[0] ? 1'b0 : 1'b1;
      repeat (8) @(negedge CLK);
    end
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("t6_p_data", 32'(P_DATA), 32'h0);
    check("t6_bit_cnt", 32'(bit_cnt), 32'h0);
    check("t6_sampled_bit", 32'(sampled_bit), 32'h1);
    check("t6_par_chk_en", 32'(par_chk_en), 32'h0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_edge_cnt", 32'(dbg_edge_cnt), 32'h0);
    @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    idle(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 0, 0, 1, 8, 8, -1, 0);
    idle(6);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
